// File: rtl/ad7124_tc_scan_buffer.sv
// ad7124_tc_scan_buffer
// Gathers one scan of NUM_OF_CHANNEL AD7124 conversion results into a write
// bank. When every channel has arrived, the bank is published to the fusion
// stage through a ping-pong swap, and drdy pulses.
//
// Ports
//   clk, resetn       clock; synchronous active-low reset
//   s_valid, s_data   conversion strobe; {code[23:0], status[7:0]}
//   bram_en/addr/dout registered read port on the published bank (1-cycle latency)
//   drdy              one-cycle pulse when a new scan has been published
//   scan_count        number of published scans (wraps)
//   err_flags         sticky: [0] bad channel, [1] duplicate, [2] ADC ERROR, [3] timeout
//   err_clear         clears err_flags (a set in the same cycle wins)
//
// state     | meaning
// S_IDLE    | no scan in progress, mask empty
// S_COLLECT | gathering channels; timeout counter running
// S_PUBLISH | scan complete; drdy is raised on leaving this state
module ad7124_tc_scan_buffer #(
    parameter int NUM_OF_CHANNEL = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    input  logic        bram_en,
    input  logic [2:0]  bram_addr,
    output logic [31:0] bram_dout,
    output logic        drdy,
    output logic [31:0] scan_count,
    output logic [3:0]  err_flags,
    input  logic        err_clear
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_OF_CHANNEL-1:0] MASK_FULL = '1;
    localparam logic [NUM_OF_CHANNEL-1:0] BIT0 = 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PUBLISH} state_t;

    state_t state, state_next;

    logic [31:0]               bank [2][NUM_OF_CHANNEL];
    logic                      wr_sel;
    logic                      wsel_eff;
    logic [NUM_OF_CHANNEL-1:0] mask;
    logic [NUM_OF_CHANNEL-1:0] ch_bit;
    logic [NUM_OF_CHANNEL-1:0] acc_bit;
    logic [CW-1:0]             tmo_cnt;
    logic [3:0]                ch;
    logic                      ch_ok;
    logic                      bad_ch;
    logic                      dup;
    logic                      start;
    logic                      publish;
    logic                      abort;

    assign ch      = s_data[3:0];
    assign ch_ok   = s_valid && (ch < 4'(NUM_OF_CHANNEL));
    assign bad_ch  = s_valid && !(ch < 4'(NUM_OF_CHANNEL));
    assign ch_bit  = BIT0 << ch[2:0];
    assign acc_bit = ch_ok ? ch_bit : '0;
    assign dup     = ch_ok && (state == S_COLLECT) && ((mask & ch_bit) != '0);

    // wr_sel only flips on the edge that ends drdy, but a scan may start in
    // the PUBLISH cycle or the drdy cycle; those samples belong to the bank
    // that becomes the write bank after the swap.
    assign wsel_eff = wr_sel ^ ((state == S_PUBLISH) || drdy);

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        publish    = 1'b0;
        abort      = 1'b0;
        case (state)
            S_IDLE: begin
                if (ch_ok) begin
                    state_next = S_COLLECT;
                    start      = 1'b1;
                end
            end
            S_COLLECT: begin
                if ((mask | acc_bit) == MASK_FULL) begin
                    state_next = S_PUBLISH;
                end else if (tmo_cnt == TC_LAST) begin
                    state_next = S_IDLE;
                    abort      = 1'b1;
                end
            end
            S_PUBLISH: begin
                publish = 1'b1;
                if (ch_ok) begin
                    state_next = S_COLLECT;
                    start      = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NUM_OF_CHANNEL; i++)
                    bank[b][i] <= '0;
            wr_sel     <= 1'b0;
            mask       <= '0;
            tmo_cnt    <= '0;
            drdy       <= 1'b0;
            scan_count <= '0;
            err_flags  <= '0;
            bram_dout  <= '0;
        end else begin
            drdy <= publish;
            if (drdy) begin
                wr_sel     <= ~wr_sel;
                scan_count <= scan_count + 32'd1;
            end

            if (ch_ok)
                bank[wsel_eff][ch[2:0]] <= {s_data[7:0], s_data[31:8]};

            if (start)
                mask <= ch_bit;
            else if (publish || abort)
                mask <= '0;
            else if (state == S_COLLECT)
                mask <= mask | acc_bit;

            if (start)
                tmo_cnt <= '0;
            else if ((state == S_COLLECT) && (tmo_cnt != TC_LAST))
                tmo_cnt <= tmo_cnt + CW'(1);

            err_flags <= (err_flags & ~{4{err_clear}})
                       | {abort, ch_ok && s_data[6], dup, bad_ch};

            if (bram_en) begin
                if ({1'b0, bram_addr} < 4'(NUM_OF_CHANNEL))
                    bram_dout <= bank[~wr_sel][bram_addr];
                else
                    bram_dout <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ad7124_tc_scan_buffer.sv
// Directed bench for ad7124_tc_scan_buffer (built with TIMEOUT_CYCLES=64).
module tb_ad7124_tc_scan_buffer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        bram_en = 1'b0;
    logic [2:0]  bram_addr = '0;
    logic [31:0] bram_dout;
    logic        drdy;
    logic [31:0] scan_count;
    logic [3:0]  err_flags;
    logic        err_clear = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int drdy_cnt = 0;

    ad7124_tc_scan_buffer #(.NUM_OF_CHANNEL(8), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_data(s_data),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .drdy(drdy), .scan_count(scan_count), .err_flags(err_flags),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (drdy) drdy_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // leaves s_valid high so consecutive calls are back-to-back
    task automatic drive(input int ch, input logic [23:0] code, input logic [7:0] status);
        s_data  = {code, status};
        s_valid = 1'b1;
        tick();
    endtask

    task automatic idle();
        s_valid = 1'b0;
    endtask

    task automatic rd(input int addr, output logic [31:0] val);
        bram_en   = 1'b1;
        bram_addr = 3'(addr);
        tick();
        bram_en = 1'b0;
        val = bram_dout;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int d0;
        #1;
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        check("rst_dout", bram_dout, 32'h0);
        check("rst_drdy", {31'b0, drdy}, 32'h0);
        check("rst_scan_count", scan_count, 32'h0);
        check("rst_err", {28'b0, err_flags}, 32'h0);

        // scan publish: back-to-back ch0..7, last strobe at edge N
        for (int i = 0; i < 8; i++) drive(i, 24'h800000 + 24'(i), 8'(i));
        idle();
        check("pub_drdy_n", {31'b0, drdy}, 32'h0);
        tick();
        check("pub_drdy_n1", {31'b0, drdy}, 32'h1);
        check("pub_cnt_n1", scan_count, 32'h0);
        tick();
        check("pub_drdy_n2", {31'b0, drdy}, 32'h0);
        check("pub_cnt_n2", scan_count, 32'h1);
        check("pub_drdy_pulses", drdy_cnt, 1);
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            check("pub_rd", v, {8'(i), 24'h800000 + 24'(i)});
        end

        // out-of-order with duplicate on ch3
        d0 = drdy_cnt;
        drive(3, 24'h100003, 8'h03);
        drive(1, 24'h100001, 8'h01);
        drive(3, 24'hABCDEF, 8'h03);
        drive(0, 24'h100000, 8'h00);
        drive(2, 24'h100002, 8'h02);
        for (int i = 4; i < 8; i++) drive(i, 24'h100000 + 24'(i), 8'(i));
        idle();
        repeat (3) tick();
        check("ooo_drdy", drdy_cnt - d0, 1);
        check("ooo_cnt", scan_count, 32'h2);
        check("ooo_err", {28'b0, err_flags}, 32'h2);
        rd(3, v);
        check("ooo_rd3", v, 32'h03ABCDEF);
        rd(1, v);
        check("ooo_rd1", v, 32'h01100001);
        rd(7, v);
        check("ooo_rd7", v, 32'h07100007);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clr_err0", {28'b0, err_flags}, 32'h0);

        // invalid channel, then ERROR-tagged sample
        drive(9, 24'h123456, 8'h49);
        idle();
        tick();
        check("inv_err", {28'b0, err_flags}, 32'h1);
        drive(5, 24'h654321, 8'h45);
        idle();
        tick();
        check("errbit_err", {28'b0, err_flags}, 32'h5);
        // clear and a new bad-channel set in the same cycle: the set survives
        err_clear = 1'b1;
        drive(9, 24'h0, 8'h09);
        idle();
        err_clear = 1'b0;
        check("clr_vs_set", {28'b0, err_flags}, 32'h1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clr_err1", {28'b0, err_flags}, 32'h0);
        // the lone ch5 sample left a scan open; let it time out
        d0 = drdy_cnt;
        repeat (70) tick();
        check("stray_tmo_err", {28'b0, err_flags}, 32'h8);
        check("stray_tmo_cnt", scan_count, 32'h2);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // timeout: ch0..6 only; ch0 accepted at edge E0
        for (int i = 0; i < 7; i++) drive(i, 24'h700000 + 24'(i), 8'(i));
        idle();
        repeat (57) tick();
        check("tmo_e63", {28'b0, err_flags}, 32'h0);
        tick();
        check("tmo_e64", {28'b0, err_flags}, 32'h8);
        check("tmo_drdy", drdy_cnt - d0, 0);
        check("tmo_cnt", scan_count, 32'h2);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        for (int i = 0; i < 8; i++) drive(i, 24'h200000 + 24'(i), 8'(i));
        idle();
        repeat (3) tick();
        check("after_tmo_drdy", drdy_cnt - d0, 1);
        check("after_tmo_cnt", scan_count, 32'h3);
        rd(6, v);
        check("after_tmo_rd6", v, 32'h06200006);

        // ping-pong: continuous read of addr 2 while scan B arrives
        bram_en   = 1'b1;
        bram_addr = 3'd2;
        tick();
        check("pp_pre", bram_dout, 32'h02200002);
        for (int i = 0; i < 8; i++) begin
            drive(i, 24'h300000 + 24'(i), 8'(i));
            check("pp_during", bram_dout, 32'h02200002);
        end
        idle();
        tick();
        check("pp_n1", bram_dout, 32'h02200002);
        tick();
        check("pp_swap_edge", bram_dout, 32'h02200002);
        tick();
        check("pp_after", bram_dout, 32'h02300002);
        bram_en = 1'b0;
        tick();
        check("pp_hold", bram_dout, 32'h02300002);
        check("pp_cnt", scan_count, 32'h4);

        // reset mid-scan
        for (int i = 0; i < 5; i++) drive(i, 24'h400000 + 24'(i), 8'(i));
        idle();
        do_reset();
        check("mid_rst_cnt", scan_count, 32'h0);
        rd(0, v);
        check("mid_rst_bank0", v, 32'h0);
        d0 = drdy_cnt;
        for (int i = 0; i < 8; i++) drive(i, 24'h500000 + 24'(i), 8'(i));
        idle();
        repeat (3) tick();
        check("mid_rst_drdy", drdy_cnt - d0, 1);
        check("mid_rst_scan", scan_count, 32'h1);
        check("mid_rst_err", {28'b0, err_flags}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            check("mid_rst_rd", v, {8'(i), 24'h500000 + 24'(i)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
